// File: rtl/tmr_channel.sv
// Single timer channel: TDR/TCR/TSR/TCNT register block with prescaler, auto-reload, one-shot and irq.
// Latency: register writes land at the next tmr_clk edge; reads are combinational; irq follows TSR/TCR state directly.
// Backpressure: none; an access counts only when sel, enable and ready are high with exactly one register selected.
module tmr_channel #(
    parameter int CNT_WIDTH = 8,
    parameter int CKS_WIDTH = 2
) (
    input  logic                 tmr_clk,
    input  logic                 tmr_reset_n,
    input  logic                 tmr_sel,
    input  logic                 tmr_write,
    input  logic                 tmr_enable,
    input  logic [3:0]           tmr_selected_reg,
    input  logic [CNT_WIDTH-1:0] tmr_wdata,
    input  logic                 tmr_ready,
    output logic [CNT_WIDTH-1:0] tmr_rdata,
    output logic [CNT_WIDTH-1:0] tmr_cnt,
    output logic                 tmr_ovf,
    output logic                 tmr_udf,
    output logic                 tmr_irq
);

    // Prescaler is one bit per selectable divide ratio so the widest ratio
    // (cks at its maximum) still sees a full all-ones window.
    localparam int DIV_WIDTH = 1 << CKS_WIDTH;

    // TCR only carries a 2-bit cks field; narrower CKS_WIDTH leaves the
    // upper cks bit unimplemented (reads 0).
    localparam int         CKS_USED = (CKS_WIDTH < 2) ? CKS_WIDTH : 2;
    localparam logic [1:0] CKS_MASK = (CKS_USED >= 2) ? 2'b11 :
                                      (CKS_USED == 1) ? 2'b01 : 2'b00;
    localparam logic [7:0] TCR_MASK = {6'b111111, CKS_MASK};

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    // Control register layout, MSB first, as seen in the low byte of the bus.
    typedef struct packed {
        logic       load;
        logic       one_shot;
        logic       down;
        logic       en;
        logic       ie;
        logic       auto_reload;
        logic [1:0] cks;
    } tcr_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    tcr_t                 tcr_q;
    logic [CNT_WIDTH-1:0] tdr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;
    logic                 udf_q;
    logic [DIV_WIDTH-1:0] div_q;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic sel_one;
    logic access;
    logic wr;
    logic rd;
    logic tdr_wr;
    logic tcr_wr;
    logic tsr_wr;

    assign sel_one = $onehot(tmr_selected_reg);
    assign access  = tmr_sel & tmr_enable & tmr_ready & sel_one;
    assign wr      = access & tmr_write;
    assign rd      = access & ~tmr_write;

    // TCNT (select bit 3) has no write strobe: it is read-only from the bus.
    assign tdr_wr  = wr & tmr_selected_reg[0];
    assign tcr_wr  = wr & tmr_selected_reg[1];
    assign tsr_wr  = wr & tmr_selected_reg[2];

    // ------------------------------------------------------------------
    // Prescaler tick
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] tick_mask;
    logic                 tick;

    // Build a mask covering divider bits [cks:0]; tick fires when they are all ones.
    always_comb begin
        tick_mask = '0;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            tick_mask[i] = (i <= int'(tcr_q.cks));
        end
    end

    assign tick = tcr_q.en & ((div_q & tick_mask) == tick_mask);

    // ------------------------------------------------------------------
    // Counter next-state
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 set_ovf;
    logic                 set_udf;
    logic                 wrap;

    // Load beats counting; a tick at a boundary wraps (or reloads) and raises a flag.
    always_comb begin
        cnt_d   = cnt_q;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        wrap    = 1'b0;
        if (tcr_q.load) begin
            cnt_d = tdr_q;
        end else if (tick) begin
            if (!tcr_q.down) begin
                if (cnt_q == CNT_MAX) begin
                    wrap    = 1'b1;
                    set_ovf = 1'b1;
                    cnt_d   = tcr_q.auto_reload ? tdr_q : CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else begin
                if (cnt_q == CNT_ZERO) begin
                    wrap    = 1'b1;
                    set_udf = 1'b1;
                    cnt_d   = tcr_q.auto_reload ? tdr_q : CNT_MAX;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Divider runs only while enabled and restarts on any TCR write so a new cks starts from a clean phase.
    always_ff @(posedge tmr_clk or negedge tmr_reset_n) begin
        if (!tmr_reset_n) begin
            div_q <= '0;
        end else if (tcr_wr || !tcr_q.en) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    // Software write wins over the one-shot hardware clear of en.
    always_ff @(posedge tmr_clk or negedge tmr_reset_n) begin
        if (!tmr_reset_n) begin
            tcr_q <= '0;
        end else if (tcr_wr) begin
            tcr_q <= tcr_t'(tmr_wdata[7:0] & TCR_MASK);
        end else if (wrap && tcr_q.one_shot) begin
            tcr_q.en <= 1'b0;
        end
    end

    // Data/reload register, plain read/write.
    always_ff @(posedge tmr_clk or negedge tmr_reset_n) begin
        if (!tmr_reset_n) begin
            tdr_q <= '0;
        end else if (tdr_wr) begin
            tdr_q <= tmr_wdata;
        end
    end

    // Counter takes whatever the next-state logic decided.
    always_ff @(posedge tmr_clk or negedge tmr_reset_n) begin
        if (!tmr_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Sticky flags, write-1-to-clear; a hardware set in the same cycle keeps the flag high.
    always_ff @(posedge tmr_clk or negedge tmr_reset_n) begin
        if (!tmr_reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= set_ovf | (ovf_q & ~(tsr_wr & tmr_wdata[0]));
            udf_q <= set_udf | (udf_q & ~(tsr_wr & tmr_wdata[1]));
        end
    end

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------

    // Zero-extended register read, forced to 0 unless a clean read access is in progress.
    always_comb begin
        tmr_rdata = '0;
        if (rd) begin
            if (tmr_selected_reg[0]) begin
                tmr_rdata = tdr_q;
            end else if (tmr_selected_reg[1]) begin
                tmr_rdata = CNT_WIDTH'(tcr_q);
            end else if (tmr_selected_reg[2]) begin
                tmr_rdata = CNT_WIDTH'({udf_q, ovf_q});
            end else begin
                tmr_rdata = cnt_q;
            end
        end
    end

    assign tmr_cnt = cnt_q;
    assign tmr_ovf = ovf_q;
    assign tmr_udf = udf_q;
    assign tmr_irq = tcr_q.ie & (ovf_q | udf_q);

endmodule

// File: tb/tb_tmr_channel.sv
// Bench for tmr_channel: 8-bit channel against a behavioural model plus a 16-bit wrap/async-reset check.
// Latency: model state tracks registered state; outputs are compared on the falling edge.
// Backpressure: bus qualifiers (sel/enable/ready) are randomised; illegal selects are exercised.
module tb_tmr_channel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit channel
    logic       rst_n;
    logic       sel, write, enable, ready;
    logic [3:0] sel_reg;
    logic [7:0] wdata, rdata, cnt;
    logic       ovf, udf, irq;

    // 16-bit channel
    logic        b_rst_n;
    logic        b_sel, b_write, b_enable, b_ready;
    logic [3:0]  b_sel_reg;
    logic [15:0] b_wdata, b_rdata, b_cnt;
    logic        b_ovf, b_udf, b_irq;

    tmr_channel #(.CNT_WIDTH(8), .CKS_WIDTH(2)) u_dut8 (
        .tmr_clk(clk), .tmr_reset_n(rst_n), .tmr_sel(sel), .tmr_write(write),
        .tmr_enable(enable), .tmr_selected_reg(sel_reg), .tmr_wdata(wdata),
        .tmr_ready(ready), .tmr_rdata(rdata), .tmr_cnt(cnt), .tmr_ovf(ovf),
        .tmr_udf(udf), .tmr_irq(irq)
    );

    tmr_channel #(.CNT_WIDTH(16), .CKS_WIDTH(2)) u_dut16 (
        .tmr_clk(clk), .tmr_reset_n(b_rst_n), .tmr_sel(b_sel), .tmr_write(b_write),
        .tmr_enable(b_enable), .tmr_selected_reg(b_sel_reg), .tmr_wdata(b_wdata),
        .tmr_ready(b_ready), .tmr_rdata(b_rdata), .tmr_cnt(b_cnt), .tmr_ovf(b_ovf),
        .tmr_udf(b_udf), .tmr_irq(b_irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model of the 8-bit channel (registered state only)
    // ------------------------------------------------------------------
    logic [7:0]  m_tdr, m_tcr, m_cnt;
    bit          m_ovf, m_udf;
    int unsigned m_age;   // cycles the prescaler has been running since it was last cleared

    function automatic bit m_tick();
        int unsigned p;
        p = 2 << m_tcr[1:0];
        return m_tcr[4] && ((m_age % p) == p - 1);
    endfunction

    task automatic m_step(input bit wr, input logic [3:0] rs, input logic [7:0] wd);
        int nxt;
        bit wrap, so, su, tcr_w;
        wrap = 0; so = 0; su = 0;
        tcr_w = wr && (rs == 4'b0010);
        if (m_tcr[7]) begin
            nxt = int'(m_tdr);
        end else if (m_tick()) begin
            nxt = m_tcr[5] ? int'(m_cnt) - 1 : int'(m_cnt) + 1;
            if (nxt > 255) begin
                so = 1; wrap = 1; nxt = m_tcr[2] ? int'(m_tdr) : 0;
            end else if (nxt < 0) begin
                su = 1; wrap = 1; nxt = m_tcr[2] ? int'(m_tdr) : 255;
            end
        end else begin
            nxt = int'(m_cnt);
        end
        m_ovf = so || (m_ovf && !(wr && rs == 4'b0100 && wd[0]));
        m_udf = su || (m_udf && !(wr && rs == 4'b0100 && wd[1]));
        if (tcr_w || !m_tcr[4]) m_age = 0;
        else                    m_age = m_age + 1;
        if (tcr_w)                     m_tcr = wd;
        else if (wrap && m_tcr[6])     m_tcr[4] = 1'b0;
        if (wr && rs == 4'b0001) m_tdr = wd;
        m_cnt = 8'(nxt);
    endtask

    logic [7:0] last_rdata, last_cnt;
    logic       last_ovf, last_udf, last_irq;

    // One bus cycle on the 8-bit channel: drive, compare on falling edge, advance model.
    task automatic cyc8(input bit s, input bit w, input bit e, input bit r,
                        input logic [3:0] rs, input logic [7:0] wd);
        bit acc, wr, rd;
        logic [7:0] exp_rd;
        sel = s; write = w; enable = e; ready = r; sel_reg = rs; wdata = wd;
        acc = s && e && r && $onehot(rs);
        wr  = acc && w;
        rd  = acc && !w;
        exp_rd = 8'h00;
        if (rd) begin
            if (rs[0])      exp_rd = m_tdr;
            else if (rs[1]) exp_rd = m_tcr;
            else if (rs[2]) exp_rd = {6'b0, m_udf, m_ovf};
            else            exp_rd = m_cnt;
        end
        @(negedge clk);
        last_rdata = rdata; last_cnt = cnt; last_ovf = ovf; last_udf = udf; last_irq = irq;
        chk("rdata", rdata, exp_rd);
        chk("cnt", cnt, m_cnt);
        chk("ovf", ovf, m_ovf);
        chk("udf", udf, m_udf);
        chk("irq", irq, m_tcr[3] && (m_ovf || m_udf));
        m_step(wr, rs, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic wr8(input logic [3:0] rs, input logic [7:0] wd);
        cyc8(1, 1, 1, 1, rs, wd);
    endtask

    task automatic rd8(input logic [3:0] rs);
        cyc8(1, 0, 1, 1, rs, 8'h00);
    endtask

    task automatic idle8(input int n);
        for (int i = 0; i < n; i++) cyc8(0, 0, 0, 0, 4'b0000, 8'h00);
    endtask

    task automatic cyc16(input bit s, input bit w, input logic [3:0] rs, input logic [15:0] wd);
        b_sel = s; b_write = w; b_enable = s; b_ready = s; b_sel_reg = rs; b_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp1 [7] = '{8'hFD, 8'hFD, 8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00};

    initial begin
        bit         found;
        logic [7:0] exp_c;

        rst_n = 0; b_rst_n = 0;
        sel = 1; write = 0; enable = 1; ready = 1; sel_reg = 4'b0001; wdata = 0;
        b_sel = 0; b_write = 0; b_enable = 0; b_ready = 0; b_sel_reg = 0; b_wdata = 0;
        m_tdr = 0; m_tcr = 0; m_cnt = 0; m_ovf = 0; m_udf = 0; m_age = 0;

        // Outputs while held in reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_irq", irq, 0);
        rst_n = 1; b_rst_n = 1;
        @(posedge clk);
        #1;

        // Reset values of every register
        for (int i = 0; i < 4; i++) begin
            rd8(4'(1 << i));
            chk("rst_reg", last_rdata, 0);
        end

        // Up count with overflow and irq
        wr8(4'b0001, 8'hFD);
        wr8(4'b0010, 8'h80);
        wr8(4'b0010, 8'h18);
        for (int k = 0; k < 7; k++) begin
            idle8(1);
            chk("t1_cnt", last_cnt, exp1[k]);
            if (k == 5) chk("t1_ovf_pre", last_ovf, 0);
        end
        chk("t1_ovf", last_ovf, 1);
        chk("t1_irq", last_irq, 1);

        // Down count, cks=1, auto-reload, irq masked
        wr8(4'b0100, 8'h03);
        wr8(4'b0001, 8'h03);
        wr8(4'b0010, 8'h80);
        wr8(4'b0010, 8'h35);
        for (int k = 1; k <= 17; k++) begin
            idle8(1);
            chk("t2_cnt", last_cnt, (k <= 16) ? (3 - (k - 1) / 4) : 3);
            if (k == 16) chk("t2_udf_pre", last_udf, 0);
        end
        chk("t2_udf", last_udf, 1);
        chk("t2_irq", last_irq, 0);

        // One-shot
        wr8(4'b0100, 8'h03);
        wr8(4'b0001, 8'hFE);
        wr8(4'b0010, 8'h80);
        wr8(4'b0010, 8'h50);
        for (int k = 1; k <= 10; k++) begin
            idle8(1);
            chk("t3_cnt", last_cnt, (k <= 2) ? 8'hFE : (k <= 4) ? 8'hFF : 8'h00);
        end
        chk("t3_ovf", last_ovf, 1);
        rd8(4'b0010);
        chk("t3_tcr", last_rdata, 8'h40);

        // Clear racing a hardware set, then a clean clear
        wr8(4'b0100, 8'h03);
        wr8(4'b0001, 8'hFE);
        wr8(4'b0010, 8'h80);
        wr8(4'b0010, 8'h18);
        found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (m_cnt == 8'hFF && m_tick()) found = 1;
            else idle8(1);
        end
        chk("t4_found", found, 1);
        wr8(4'b0100, 8'h01);
        chk("t4_ovf_pre", last_ovf, 0);
        chk("t4_ovf_keep", ovf, 1);
        wr8(4'b0010, 8'h08);
        idle8(2);
        chk("t4_irq_hi", last_irq, 1);
        wr8(4'b0100, 8'h01);
        chk("t4_ovf_clr", ovf, 0);
        chk("t4_irq_lo", irq, 0);

        // Bus edge cases
        cyc8(1, 0, 1, 0, 4'b0001, 8'h00);
        chk("t5_rd_notready", last_rdata, 0);
        wr8(4'b0011, 8'hAA);
        rd8(4'b0001);
        chk("t5_tdr_keep", last_rdata, 8'hFE);
        rd8(4'b0010);
        chk("t5_tcr_keep", last_rdata, 8'h08);
        exp_c = m_cnt;
        wr8(4'b1000, 8'h55);
        idle8(1);
        chk("t5_tcnt_ro", last_cnt, exp_c);

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            bit s, w, e, r;
            logic [3:0] rs;
            logic [7:0] wd;
            s = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 7) == 0) rs = 4'($urandom);
            else                           rs = 4'(1 << $urandom_range(0, 3));
            wd = 8'($urandom);
            if (rs == 4'b0001) wd = ($urandom_range(0, 1) != 0) ? {5'h1F, wd[2:0]} : {5'h00, wd[2:0]};
            if (rs == 4'b0010) begin
                wd[7] = ($urandom_range(0, 15) == 0);
                wd[4] = ($urandom_range(0, 3) != 0);
            end
            cyc8(s, w, e, r, rs, wd);
        end

        // 16-bit wrap, then asynchronous reset between edges
        cyc16(1, 1, 4'b0001, 16'hFFFF);
        cyc16(1, 1, 4'b0010, 16'h0080);
        cyc16(1, 1, 4'b0010, 16'h0018);
        chk("t6_cnt_ld", b_cnt, 16'hFFFF);
        cyc16(0, 0, 4'b0000, 16'h0000);
        chk("t6_cnt_hold", b_cnt, 16'hFFFF);
        cyc16(0, 0, 4'b0000, 16'h0000);
        chk("t6_wrap", b_cnt, 16'h0000);
        chk("t6_ovf", b_ovf, 1);
        chk("t6_irq", b_irq, 1);
        repeat (3) cyc16(0, 0, 4'b0000, 16'h0000);
        b_sel = 1; b_write = 0; b_enable = 1; b_ready = 1; b_sel_reg = 4'b0001;
        #1;
        chk("t6_rd_pre", b_rdata, 16'hFFFF);
        #2;
        b_rst_n = 0;
        #1;
        chk("t6_rst_cnt", b_cnt, 0);
        chk("t6_rst_ovf", b_ovf, 0);
        chk("t6_rst_udf", b_udf, 0);
        chk("t6_rst_irq", b_irq, 0);
        chk("t6_rst_rdata", b_rdata, 0);
        @(posedge clk);
        #1;
        b_rst_n = 1;
        b_sel_reg = 4'b0010;
        #1;
        chk("t6_rst_tcr", b_rdata, 0);
        @(posedge clk);
        #1;
        chk("t6_rst_cnt_hold", b_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
